// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master fed from a small {last,data} TX FIFO; returns the MISO byte of each frame.
// Define SPI_LSB_FIRST_EN to shift tx and rx bits LSB first (timing and framing unchanged).
module spi_byte_master #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       busy,
  output logic       sck_o,
  output logic       mosi_o,
  output logic       cs_n_o,
  input  logic       miso_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  RELOAD   = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_SHIFT, ST_WAIT, ST_HOLD, ST_DESEL
  } state_t;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, fifo_empty;
  logic [8:0]    head;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] edge_q, edge_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic       sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d, last_q, last_d;
  logic       rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
  logic       tick;

  // tx_ready comes from the registered count only, so a pop frees a full slot one cycle later.
  assign tx_ready   = (count_q != FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = tx_valid && tx_ready;
  assign head       = mem_q[rd_ptr_q];
  assign tick       = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {tx_last, tx_data};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // tx_sh holds only the bits still to be driven after the one already on mosi.
  logic [7:0] tx_load, tx_shifted, rx_shifted;
  logic       first_bit, next_bit;
`ifdef SPI_LSB_FIRST_EN
  assign first_bit  = head[0];
  assign tx_load    = {1'b0, head[7:1]};
  assign next_bit   = tx_sh_q[0];
  assign tx_shifted = {1'b0, tx_sh_q[7:1]};
  assign rx_shifted = {miso_i, rx_sh_q[7:1]};
`else
  assign first_bit  = head[7];
  assign tx_load    = {head[6:0], 1'b0};
  assign next_bit   = tx_sh_q[7];
  assign tx_shifted = {tx_sh_q[6:0], 1'b0};
  assign rx_shifted = {rx_sh_q[6:0], miso_i};
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    edge_d       = edge_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    rx_data_d    = rx_data_q;
    sck_d        = sck_q;
    mosi_d       = mosi_q;
    cs_n_d       = cs_n_q;
    last_d       = last_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = 1'b0;
    pop          = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (!tick) cnt_d = cnt_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cs_n_d  = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          cnt_d   = RELOAD;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          cnt_d  = RELOAD;
          sck_d  = ~sck_q;
          edge_d = edge_q + 1'b1;
          if (!sck_q) begin
            rx_sh_d = rx_shifted;
          end else if (edge_q != 4'd15) begin
            tx_sh_d = tx_shifted;
            mosi_d  = next_bit;
          end else begin
            // Byte done: a new byte always wins over a same-cycle consume.
            rx_data_d    = rx_sh_q;
            rx_valid_d   = 1'b1;
            rx_overrun_d = rx_valid_q && !rx_ready;
            if (last_q)           state_d = ST_HOLD;
            else if (!fifo_empty) pop     = 1'b1;
            else                  state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          cnt_d   = RELOAD;
          state_d = ST_DESEL;
        end
      end
      ST_DESEL: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      tx_sh_d = tx_load;
      mosi_d  = first_bit;
      last_d  = head[8];
      edge_d  = '0;
      cnt_d   = RELOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      edge_q       <= '0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      rx_data_q    <= '0;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      last_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      edge_q       <= edge_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      rx_data_q    <= rx_data_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      last_q       <= last_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign sck_o      = sck_q;
  assign mosi_o     = mosi_q;
  assign cs_n_o     = cs_n_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: SPI slave model + bus monitor, table vectors, corner sequences, random traffic.
`timescale 1ns/1ps
module tb_spi_byte_master;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int BYTE_CYC   = 16 * CLK_DIV;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0, tx_valid = 1'b0, rx_ready = 1'b1, miso_i = 1'b0;
  logic       tx_ready, rx_valid, rx_overrun, busy, sck_o, mosi_o, cs_n_o;
  logic [7:0] rx_data;

  spi_byte_master #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .busy(busy), .sck_o(sck_o), .mosi_o(mosi_o), .cs_n_o(cs_n_o),
    .miso_i(miso_i)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Slave/monitor state; bit order of the wire follows the build option.
  int cyc = 0, s_idx = 0, s_bit = 0, m_cnt = 0;
  int frames = 0, pulses = 0, overruns = 0, bad_hi = 0, bad_gap = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, cs_len = 0, desel_gap = 0, hi_len = 0, lo_len = 0;
  logic prev_sck = 1'b0, prev_cs = 1'b1, train = 1'b0;
  logic [7:0] m_sh = 8'h00;
  logic [7:0] slave_q[$], mosi_got[$], rx_got[$], exp_mosi[$], exp_rx[$];

  function automatic int bit_pos(input int i);
`ifdef SPI_LSB_FIRST_EN
    return i;
`else
    return 7 - i;
`endif
  endfunction

  function automatic logic slave_bit();
    logic [7:0] b;
    b = (s_idx < slave_q.size()) ? slave_q[s_idx] : 8'h00;
    return b[bit_pos(s_bit)];
  endfunction

  always @(posedge clk) begin
    #1;
    cyc++;
    if (prev_cs && !cs_n_o) begin
      cs_fall_cyc = cyc; desel_gap = cyc - cs_rise_cyc;
      s_bit = 0; m_cnt = 0; train = 1'b0;
      miso_i = slave_bit();
    end
    if (!prev_cs && cs_n_o) begin
      frames++; cs_len = cyc - cs_fall_cyc; cs_rise_cyc = cyc;
      $display("frame end: cs low %0d cycles", cs_len);
    end
    if (!prev_sck && sck_o) begin
      pulses++;
      if (train && lo_len != CLK_DIV) bad_gap++;
      train = 1'b1; hi_len = 0;
      m_sh[bit_pos(m_cnt)] = mosi_o;
      m_cnt++;
      if (m_cnt == 8) begin
        mosi_got.push_back(m_sh); m_cnt = 0;
        $display("mosi byte %02h", m_sh);
      end
    end
    if (prev_sck && !sck_o) begin
      if (hi_len != CLK_DIV) bad_hi++;
      lo_len = 0;
      if (!cs_n_o) begin
        s_bit++;
        if (s_bit == 8) begin s_bit = 0; s_idx++; end
        miso_i = slave_bit();
      end
    end
    if (sck_o) hi_len++; else lo_len++;
    if (rx_valid && rx_ready) rx_got.push_back(rx_data);
    if (rx_overrun) overruns++;
    prev_sck = sck_o; prev_cs = cs_n_o;
  end

  task automatic clear();
    mosi_got.delete(); rx_got.delete(); slave_q.delete(); exp_mosi.delete(); exp_rx.delete();
    s_idx = 0; frames = 0; pulses = 0; overruns = 0; bad_hi = 0; bad_gap = 0;
  endtask

  task automatic push(input logic [7:0] d, input logic l, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    if (!tx_ready) check("push_ready_timeout", tx_ready, 1);
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (frames < n && k < budget) begin @(negedge clk); k++; end
    check({tag, "_frames"}, frames, n);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_streams(input string tag, input logic do_rx);
    check({tag, "_mosi_n"}, mosi_got.size(), exp_mosi.size());
    foreach (exp_mosi[i])
      check($sformatf("%s_mosi%0d", tag, i), (i < mosi_got.size()) ? {8'h00, mosi_got[i]} : 16'hFFFF, exp_mosi[i]);
    if (do_rx) begin
      check({tag, "_rx_n"}, rx_got.size(), exp_rx.size());
      foreach (exp_rx[i])
        check($sformatf("%s_rx%0d", tag, i), (i < rx_got.size()) ? {8'h00, rx_got[i]} : 16'hFFFF, exp_rx[i]);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slave;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
    int         exp_cs_len;
    int         exp_pulses;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int acc, k, bad, n_last;
    logic [4:0] rdy;
    logic [7:0] rd[16], rs[16];
    logic rl[16];

    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 2*CLK_DIV + BYTE_CYC, 8};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 2*CLK_DIV + BYTE_CYC, 8};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 2*CLK_DIV + BYTE_CYC, 8};
    vecs[3] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3, 2*CLK_DIV + BYTE_CYC, 8};
    vecs[4] = '{8'h81, 8'h7E, 8'h81, 8'h7E, 2*CLK_DIV + BYTE_CYC, 8};

    repeat (3) @(negedge clk);
    check("rst_sck", sck_o, 0);
    check("rst_mosi", mosi_o, 0);
    check("rst_cs_n", cs_n_o, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single-byte frames, rx left pending then consumed by hand.
    rx_ready = 1'b0;
    foreach (vecs[v]) begin
      clear();
      slave_q.push_back(vecs[v].slave);
      exp_mosi.push_back(vecs[v].exp_mosi);
      push(vecs[v].tx, 1'b1, acc);
      wait_frames(1, 500, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_cs_delay", v), cs_fall_cyc - acc, 1);
      check($sformatf("vec%0d_cs_len", v), cs_len, vecs[v].exp_cs_len);
      check($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
      check($sformatf("vec%0d_sck_high", v), bad_hi, 0);
      check_streams($sformatf("vec%0d", v), 1'b0);
      check($sformatf("vec%0d_rx_valid", v), rx_valid, 1);
      check($sformatf("vec%0d_rx_data", v), rx_data, vecs[v].exp_rx);
      check($sformatf("vec%0d_overrun", v), overruns, 0);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check($sformatf("vec%0d_rx_cleared", v), rx_valid, 0);
      wait_idle($sformatf("vec%0d", v));
    end
    rx_ready = 1'b1;

    // Three bytes in one frame, contiguous SCK.
    clear();
    for (int i = 0; i < 3; i++) begin
      slave_q.push_back(8'hA1 + 8'(i * 17)); exp_rx.push_back(8'hA1 + 8'(i * 17));
      exp_mosi.push_back(8'(i + 1));
    end
    for (int i = 0; i < 3; i++) push(8'(i + 1), i == 2, acc);
    wait_frames(1, 1000, "b2b");
    check("b2b_cs_len", cs_len, 2*CLK_DIV + 3*BYTE_CYC);
    check("b2b_pulses", pulses, 24);
    check("b2b_sck_gap", bad_gap, 0);
    check_streams("b2b", 1'b1);
    wait_idle("b2b");

    // Frame held open across an empty FIFO.
    clear();
    slave_q.push_back(8'h96); slave_q.push_back(8'h69);
    exp_mosi.push_back(8'h11); exp_mosi.push_back(8'h22);
    exp_rx.push_back(8'h96); exp_rx.push_back(8'h69);
    push(8'h11, 1'b0, acc);
    k = 0;
    while (mosi_got.size() < 1 && k < 500) begin @(negedge clk); k++; end
    repeat (CLK_DIV + 2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sck_o !== 1'b0 || cs_n_o !== 1'b0) bad++;
    end
    check("gap_wait_lines", bad, 0);
    check("gap_busy", busy, 1);
    check("gap_no_frame_end", frames, 0);
    push(8'h22, 1'b1, acc);
    wait_frames(1, 1000, "gap");
    check_streams("gap", 1'b1);
    wait_idle("gap");

    // Fill the FIFO while the first byte is shifting; fifth write is dropped.
    clear();
    for (int i = 0; i < 6; i++) slave_q.push_back(8'(8'h30 + i));
    for (int i = 0; i < 5; i++) begin
      exp_mosi.push_back(8'(8'hE0 + i)); exp_rx.push_back(8'(8'h30 + i));
    end
    push(8'hE0, 1'b0, acc);
    k = 0;
    while (cs_n_o && k < 50) begin @(negedge clk); k++; end
    check("fill_started", cs_n_o, 0);
    for (int i = 0; i < 5; i++) begin
      rdy[i] = tx_ready;
      tx_data = 8'(8'hE1 + i); tx_last = (i >= 3); tx_valid = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("fill_ready_pattern", rdy, 5'b01111);
    check("fill_ready_full", tx_ready, 0);
    wait_frames(1, 2000, "fill");
    check("fill_pulses", pulses, 40);
    check_streams("fill", 1'b1);
    wait_idle("fill");

    // Two completions with no consumer.
    clear();
    rx_ready = 1'b0;
    slave_q.push_back(8'h55); slave_q.push_back(8'hAA);
    exp_mosi.push_back(8'h55); exp_mosi.push_back(8'hAA);
    push(8'h55, 1'b0, acc);
    push(8'hAA, 1'b1, acc);
    wait_frames(1, 1000, "ovr");
    check("ovr_pulses", overruns, 1);
    check("ovr_rx_data", rx_data, 8'hAA);
    check("ovr_rx_valid", rx_valid, 1);
    check_streams("ovr", 1'b0);
    rx_ready = 1'b1;
    @(negedge clk);
    check("ovr_rx_cleared", rx_valid, 0);
    wait_idle("ovr");

    // Two one-byte frames queued together: minimum deselect gap.
    clear();
    slave_q.push_back(8'h01); slave_q.push_back(8'h02);
    exp_mosi.push_back(8'h12); exp_mosi.push_back(8'h34);
    exp_rx.push_back(8'h01); exp_rx.push_back(8'h02);
    push(8'h12, 1'b1, acc);
    push(8'h34, 1'b1, acc);
    wait_frames(2, 1000, "desel");
    check("desel_gap", desel_gap, CLK_DIV + 1);
    check("desel_cs_len", cs_len, 2*CLK_DIV + BYTE_CYC);
    check_streams("desel", 1'b1);
    wait_idle("desel");

    // Asynchronous reset in the middle of a bit.
    clear();
    slave_q.push_back(8'hFF);
    push(8'h99, 1'b1, acc);
    push(8'h77, 1'b1, acc);
    k = 0;
    while (pulses < 3 && k < 500) begin @(negedge clk); k++; end
    check("rstmid_reached", pulses, 3);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_cs_n", cs_n_o, 1);
    check("rstmid_sck", sck_o, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_tx_ready", tx_ready, 1);
    check("rstmid_rx_valid", rx_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_no_rx", rx_got.size(), 0);
    check("rstmid_no_byte", mosi_got.size(), 0);
    check("rstmid_rx_data", rx_data, 0);
    clear();
    slave_q.push_back(8'h5A);
    exp_mosi.push_back(8'hC3); exp_rx.push_back(8'h5A);
    push(8'hC3, 1'b1, acc);
    wait_frames(1, 500, "rstnew");
    check("rstnew_cs_len", cs_len, 2*CLK_DIV + BYTE_CYC);
    check_streams("rstnew", 1'b1);
    wait_idle("rstnew");

    // Random bytes, frame flags and gaps against the stream model.
    clear();
    n_last = 0;
    for (int i = 0; i < 16; i++) begin
      rd[i] = 8'($urandom); rs[i] = 8'($urandom);
      rl[i] = (i == 15) || ($urandom_range(0, 2) == 0);
      n_last += int'(rl[i]);
      slave_q.push_back(rs[i]); exp_mosi.push_back(rd[i]); exp_rx.push_back(rs[i]);
    end
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      push(rd[i], rl[i], acc);
    end
    wait_frames(n_last, 20000, "rand");
    check("rand_pulses", pulses, 128);
    check("rand_sck_high", bad_hi, 0);
    check_streams("rand", 1'b1);
    wait_idle("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
